// File: rtl/hash_bram_loader.sv
// Packs a stream of 32-bit message words into 512-bit hash blocks and writes
// each block to the dual-port BRAM as two 256-bit halves in a single cycle.
module hash_bram_loader #(
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_BLK = 16,
  parameter int ADDR_W        = 4,
  parameter int RAM_W         = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_blocks,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address_a,
  output logic [ADDR_W-1:0] address_b,
  output logic [RAM_W-1:0]  data_a,
  output logic [RAM_W-1:0]  data_b,
  output logic              wren_a,
  output logic              wren_b,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W-1:0] blocks_written
);

  localparam int CNT_W = $clog2(WORDS_PER_BLK);
  localparam int BLK_W = WORDS_PER_BLK * WORD_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [BLK_W-1:0]  pack;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] num_lat;
  logic [ADDR_W:0]   bw_inc;
  logic              xfer;

  assign xfer   = in_valid && in_ready;
  assign bw_inc = {1'b0, blocks_written} + {{ADDR_W{1'b0}}, 1'b1};

  // The pack register doubles as the BRAM data outputs: the block is complete
  // and stable throughout the WRITE cycle.
  assign data_a = pack[RAM_W-1:0];
  assign data_b = pack[2*RAM_W-1:RAM_W];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (num_blocks != '0) ? FILL : DONE;
      FILL:  if (xfer && cnt == CNT_W'(WORDS_PER_BLK - 1)) state_nxt = WRITE;
      WRITE: state_nxt = (bw_inc < {1'b0, num_lat}) ? FILL : DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      pack           <= '0;
      cur_addr       <= '0;
      num_lat        <= '0;
      blocks_written <= '0;
      in_ready       <= 1'b0;
      wren_a         <= 1'b0;
      wren_b         <= 1'b0;
      busy           <= 1'b0;
      load_done      <= 1'b0;
      address_a      <= '0;
      address_b      <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == FILL);
      wren_a    <= (state_nxt == WRITE);
      wren_b    <= (state_nxt == WRITE);
      busy      <= (state_nxt != IDLE);
      load_done <= (state_nxt == DONE);

      if (state == IDLE && start && num_blocks != '0) begin
        cur_addr       <= base_addr;
        num_lat        <= num_blocks;
        blocks_written <= '0;
      end

      if (xfer) begin
        pack[cnt*WORD_W +: WORD_W] <= in_data;
        cnt                        <= cnt + CNT_W'(1);
      end

      if (state == FILL && state_nxt == WRITE) begin
        address_a <= cur_addr;
        address_b <= cur_addr + ADDR_W'(1);
      end

      if (state == WRITE) begin
        blocks_written <= bw_inc[ADDR_W-1:0];
        cur_addr       <= cur_addr + ADDR_W'(2);
        cnt            <= '0;
      end
    end
  end

endmodule
